lane_unpermute_buffer: RTL and testbench

Receive side of the lane permutation path. Takes an N-lane beat that was reordered by the gather network, together with the select vector that produced it, and restores the original lane order by applying the inverse permutation. Each beat passes through a small FIFO with valid/ready handshakes on both sides. Every select vector is checked for being a true permutation, and any violation is flagged. The block sits between the multi-lane butterfly datapath and the write-back memory ports.

---
 rtl/lane_unpermute_buffer_if.sv | 26 ++
 rtl/lane_unpermute_buffer.sv | 82 ++++++++
 tb/tb_lane_unpermute_buffer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_unpermute_buffer_if.sv
// Handshake bundle between the gather network (producer) and write-back (consumer).
// master = side driving beats in and ready out; slave = the unpermute buffer.
interface lane_unpermute_buffer_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [N*W-1:0]    in_bus;
  logic [N*SELW-1:0] sel_bus;
  logic              out_valid;
  logic              out_ready;
  logic [N*W-1:0]    out_bus;
  logic              out_perm_err;

  modport master (
    output in_valid, in_bus, sel_bus, out_ready,
    input  in_ready, out_valid, out_bus, out_perm_err
  );

  modport slave (
    input  in_valid, in_bus, sel_bus, out_ready,
    output in_ready, out_valid, out_bus, out_perm_err
  );
endinterface

// File: rtl/lane_unpermute_buffer.sv
// Applies the inverse of the gather select to each beat and queues it in a DEPTH-entry FIFO.
// One-cycle latency; in_ready depends only on FIFO occupancy, never on out_ready.
module lane_unpermute_buffer #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SELW  = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lane_unpermute_buffer_if.slave bus,
  input  logic                   err_clr,
  output logic                   err_sticky,
  output logic [15:0]            beat_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = N*W + 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW:0]         count;
  logic [N*W-1:0]      restored;
  logic                perm_err;
  logic [2**SELW-1:0]  seen;
  logic [SELW-1:0]     s;
  logic                push;
  logic                pop;

  // Ascending scan: a later source lane overwrites an earlier one on collision.
  always_comb begin
    restored = '0;
    perm_err = 1'b0;
    seen     = '0;
    s        = '0;
    for (int i = 0; i < N; i++) begin
      s = bus.sel_bus[i*SELW +: SELW];
      if (int'(s) >= N) begin
        perm_err = 1'b1;
      end else begin
        if (seen[s]) perm_err = 1'b1;
        seen[s] = 1'b1;
        restored[int'(s)*W +: W] = bus.in_bus[i*W +: W];
      end
    end
  end

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign {bus.out_bus, bus.out_perm_err} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
      beat_cnt   <= '0;
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {restored, perm_err};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        beat_cnt <= beat_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A flagged push outranks a simultaneous clear.
      if (push && perm_err) err_sticky <= 1'b1;
      else if (err_clr)     err_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lane_unpermute_buffer.sv
// Directed + randomized bench for lane_unpermute_buffer against a queue-based reference.
module tb_lane_unpermute_buffer;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SELW  = 2;
  localparam int DEPTH = 2;
  localparam logic [N*SELW-1:0] SEL_ID = 8'hE4;

  typedef struct {
    logic [N*W-1:0] dat;
    logic           err;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic        err_sticky;
  logic [15:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  entry_t      mq[$];
  logic        m_sticky = 1'b0;
  logic [15:0] m_cnt = '0;

  lane_unpermute_buffer_if #(.N(N), .W(W), .SELW(SELW)) bus ();

  lane_unpermute_buffer #(.N(N), .W(W), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .err_clr(err_clr), .err_sticky(err_sticky), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // For each destination, the highest source lane naming it supplies the data.
  function automatic entry_t ref_beat(input logic [N*W-1:0] d, input logic [N*SELW-1:0] s);
    entry_t r;
    int occ[N];
    int v;
    r.dat = '0;
    r.err = 1'b0;
    for (int k = 0; k < N; k++) occ[k] = 0;
    for (int i = 0; i < N; i++) begin
      v = int'(s[i*SELW +: SELW]);
      if (v >= N) r.err = 1'b1;
      else occ[v]++;
    end
    for (int k = 0; k < N; k++) if (occ[k] > 1) r.err = 1'b1;
    for (int dst = 0; dst < N; dst++) begin
      for (int i = N-1; i >= 0; i--) begin
        if (int'(s[i*SELW +: SELW]) == dst) begin
          r.dat[dst*W +: W] = d[i*W +: W];
          break;
        end
      end
    end
    return r;
  endfunction

  // One clock: check handshake vs model, score a pop, record a push, advance.
  task automatic step();
    logic   push, pop;
    entry_t e;
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    push = bus.in_valid && bus.in_ready;
    pop  = bus.out_valid && bus.out_ready;
    if (pop && mq.size() > 0) begin
      chk("out_bus", 64'(bus.out_bus), 64'(mq[0].dat));
      chk("out_perm_err", 64'(bus.out_perm_err), 64'(mq[0].err));
      void'(mq.pop_front());
      m_cnt = m_cnt + 16'd1;
    end
    if (push) begin
      e = ref_beat(bus.in_bus, bus.sel_bus);
      mq.push_back(e);
      if (e.err) m_sticky = 1'b1;
      else if (err_clr) m_sticky = 1'b0;
    end else if (err_clr) m_sticky = 1'b0;
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt = '0;
    end
    @(posedge clk); #1;
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
  endtask

  task automatic send(input logic [N*W-1:0] d, input logic [N*SELW-1:0] s, input bit rnd_rdy);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_bus   = d;
    bus.sel_bus  = s;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 64'(guard), 64'(0));
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    bus.out_ready = 1'b1;
    guard = 0;
    while (mq.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 64'(guard), 64'(0));
  endtask

  initial begin
    logic [N*SELW-1:0] rs;
    int perm[N];
    int j, t;

    bus.in_valid  = 1'b0;
    bus.in_bus    = '0;
    bus.sel_bus   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_bus", 64'(bus.out_bus), 64'(0));
    chk("rst_perm_err", 64'(bus.out_perm_err), 64'(0));
    chk("rst_sticky", 64'(err_sticky), 64'(0));
    chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));

    // Inverse of the gather example
    bus.out_ready = 1'b1;
    send(32'hC3A1D4B2, {2'd2, 2'd0, 2'd3, 2'd1}, 1'b0);
    chk("gather_out_bus", 64'(bus.out_bus), 64'h D4C3B2A1);
    chk("gather_err", 64'(bus.out_perm_err), 64'(0));
    step();
    chk("gather_cnt", 64'(beat_cnt), 64'(1));

    // Invalid select: duplicate destination, highest lane wins, untargeted lane zero
    bus.out_ready = 1'b0;
    send(32'h44332211, {2'd0, 2'd0, 2'd1, 2'd2}, 1'b0);
    chk("inv_out_bus", 64'(bus.out_bus), 64'h00112244);
    chk("inv_err", 64'(bus.out_perm_err), 64'(1));
    chk("inv_sticky", 64'(err_sticky), 64'(1));
    drain();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_sticky", 64'(err_sticky), 64'(0));

    // Backpressure and full
    bus.out_ready = 1'b0;
    send(32'h01010101, SEL_ID, 1'b0);
    send(32'h02020202, SEL_ID, 1'b0);
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1;
    bus.in_bus   = 32'h03030303;
    bus.sel_bus  = SEL_ID;
    step();
    bus.in_valid = 1'b0;
    chk("full_no_accept", 64'(mq.size()), 64'(2));
    bus.out_ready = 1'b1;
    chk("head_01", 64'(bus.out_bus), 64'h01010101);
    step();
    chk("head_02", 64'(bus.out_bus), 64'h02020202);
    step();
    chk("ready_back", 64'(bus.in_ready), 64'(1));

    // Simultaneous err_clr and erroring push: set wins
    bus.out_ready = 1'b1;
    err_clr = 1'b1;
    send(32'hAABBCCDD, {2'd1, 2'd1, 2'd1, 2'd1}, 1'b0);
    err_clr = 1'b0;
    chk("set_wins", 64'(err_sticky), 64'(1));
    drain();

    // Streaming across pointer wrap from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) send({N{8'(k)}}, SEL_ID, 1'b1);
    drain();
    chk("stream_cnt", 64'(beat_cnt), 64'(10));

    // Random beats: shuffled permutations mixed with arbitrary selects
    for (int b = 0; b < 150; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        rs = N*SELW'($urandom);
      end else begin
        for (int k = 0; k < N; k++) perm[k] = k;
        for (int k = N-1; k > 0; k--) begin
          j = $urandom_range(0, k);
          t = perm[k]; perm[k] = perm[j]; perm[j] = t;
        end
        for (int k = 0; k < N; k++) rs[k*SELW +: SELW] = SELW'(perm[k]);
      end
      err_clr = ($urandom_range(0, 7) == 0);
      send(N*W'($urandom), rs, 1'b1);
      err_clr = 1'b0;
    end
    drain();

    // Reset mid-stream with two entries queued
    bus.out_ready = 1'b0;
    send(32'h11111111, SEL_ID, 1'b0);
    send(32'h22222222, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_cnt", 64'(beat_cnt), 64'(0));
    chk("mid_rst_sticky", 64'(err_sticky), 64'(0));
    bus.out_ready = 1'b1;
    send(32'h5A5A5A5A, SEL_ID, 1'b0);
    chk("post_rst_bus", 64'(bus.out_bus), 64'h5A5A5A5A);
    step();

    // Counter wrap: stream until 65536 pops since reset
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel_bus   = SEL_ID;
    for (int c = 0; c < 70000 && m_cnt != 16'hFFFF; c++) begin
      bus.in_bus = N*W'(c);
      step();
    end
    chk("cnt_ffff", 64'(beat_cnt), 64'h FFFF);
    step();
    bus.in_valid = 1'b0;
    chk("cnt_wrap", 64'(beat_cnt), 64'(0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
